// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: maps signed speed commands to dead-time protected
// complementary PWM pairs, with a period-counted latching over-current shutdown.
module mtr_drv #(
    parameter int NONOVERLAP = 32,
    parameter int OVR_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    input  logic        pwr_up,
    input  logic        ovr_i,
    output logic        lft_PWM1,
    output logic        lft_PWM2,
    output logic        rght_PWM1,
    output logic        rght_PWM2,
    output logic        PWM_synch,
    output logic        ovr_fault
);

    localparam logic [11:0] NOV_W = 12'(NONOVERLAP);
    localparam logic [3:0]  LIM_W = 4'(OVR_LIMIT);

    // Offset-binary view of the signed command: -2048 -> 0, 0 -> 1024, +2047 -> 2047.
    function automatic logic [10:0] map_duty(input logic [11:0] spd);
        return {~spd[11], spd[10:1]};
    endfunction

    logic [10:0] cnt_r;
    logic [10:0] lft_duty_r;
    logic [10:0] rght_duty_r;
    logic        ovr_seen_r;
    logic [3:0]  ovr_cnt_r;

    logic        run_s;
    logic        period_end_s;
    logic        hit_s;
    logic        lft_pwm1_s;
    logic        lft_pwm2_s;
    logic        rght_pwm1_s;
    logic        rght_pwm2_s;
    logic [3:0]  ovr_cnt_nxt_s;

    // Next-state PWM levels and over-current bookkeeping.
    always_comb begin
        run_s        = pwr_up & ~ovr_fault;
        period_end_s = (cnt_r == 11'd2047);
        // PWM2 threshold is compared at 12 bits so a sum past 2047 keeps it low.
        lft_pwm1_s   = run_s && ({1'b0, cnt_r} >= NOV_W) && (cnt_r < lft_duty_r);
        lft_pwm2_s   = run_s && ({1'b0, cnt_r} >= ({1'b0, lft_duty_r} + NOV_W));
        rght_pwm1_s  = run_s && ({1'b0, cnt_r} >= NOV_W) && (cnt_r < rght_duty_r);
        rght_pwm2_s  = run_s && ({1'b0, cnt_r} >= ({1'b0, rght_duty_r} + NOV_W));
        hit_s        = ovr_i & (lft_PWM1 | lft_PWM2 | rght_PWM1 | rght_PWM2);
        if (ovr_seen_r || hit_s) begin
            if (ovr_cnt_r != 4'hF) begin
                ovr_cnt_nxt_s = ovr_cnt_r + 4'd1;
            end else begin
                ovr_cnt_nxt_s = ovr_cnt_r;
            end
        end else begin
            ovr_cnt_nxt_s = 4'd0;
        end
    end

    // Period counter, double-buffered duty, registered outputs and fault latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 11'd0;
            lft_duty_r  <= 11'd1024;
            rght_duty_r <= 11'd1024;
            lft_PWM1    <= 1'b0;
            lft_PWM2    <= 1'b0;
            rght_PWM1   <= 1'b0;
            rght_PWM2   <= 1'b0;
            PWM_synch   <= 1'b0;
            ovr_seen_r  <= 1'b0;
            ovr_cnt_r   <= 4'd0;
            ovr_fault   <= 1'b0;
        end else begin
            cnt_r     <= cnt_r + 11'd1;
            lft_PWM1  <= lft_pwm1_s;
            lft_PWM2  <= lft_pwm2_s;
            rght_PWM1 <= rght_pwm1_s;
            rght_PWM2 <= rght_pwm2_s;
            PWM_synch <= period_end_s;
            ovr_fault <= ovr_fault | (ovr_cnt_r >= LIM_W);
            if (period_end_s) begin
                lft_duty_r  <= map_duty(lft_spd);
                rght_duty_r <= map_duty(rght_spd);
                ovr_cnt_r   <= ovr_cnt_nxt_s;
                ovr_seen_r  <= 1'b0;
            end else begin
                ovr_seen_r  <= ovr_seen_r | hit_s;
            end
        end
    end

endmodule

// File: tb/tb_mtr_drv.sv
// Scoreboard bench for mtr_drv: a cycle model pushes expected outputs per clock,
// popped and compared after the edge, plus per-period high-time checks.
module tb_mtr_drv;
    localparam int NOV = 32;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        pwr_up;
    logic        ovr_i;
    logic        lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, ovr_fault;

    mtr_drv #(.NONOVERLAP(NOV), .OVR_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .pwr_up(pwr_up), .ovr_i(ovr_i),
        .lft_PWM1(lft_PWM1), .lft_PWM2(lft_PWM2),
        .rght_PWM1(rght_PWM1), .rght_PWM2(rght_PWM2),
        .PWM_synch(PWM_synch), .ovr_fault(ovr_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: counter, active duties, over-current tracking, last outputs.
    int         m_cnt  = 0;
    int         m_dl   = 1024;
    int         m_dr   = 1024;
    int         m_ocnt = 0;
    bit         m_seen = 1'b0;
    bit         m_fault = 1'b0;
    logic [5:0] m_out  = 6'd0;
    logic [5:0] exp_q[$];

    int n_l1, n_l2, n_r1, n_r2, n_sy;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int map_d(input logic [11:0] s);
        return (int'($signed(s)) + 2048) / 2;
    endfunction

    task automatic clear_win();
        n_l1 = 0; n_l2 = 0; n_r1 = 0; n_r2 = 0; n_sy = 0;
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic step();
        logic [5:0] e;
        logic [5:0] obs;
        bit         run;
        bit         hit;
        if (rst) begin
            m_cnt = 0; m_dl = 1024; m_dr = 1024;
            m_seen = 1'b0; m_ocnt = 0; m_fault = 1'b0;
            e = 6'd0;
        end else begin
            run  = pwr_up && !m_fault;
            hit  = ovr_i && (m_out[5:2] != 4'd0);
            e[5] = run && m_cnt >= NOV && m_cnt < m_dl;
            e[4] = run && m_cnt >= m_dl + NOV;
            e[3] = run && m_cnt >= NOV && m_cnt < m_dr;
            e[2] = run && m_cnt >= m_dr + NOV;
            e[1] = (m_cnt == 2047);
            e[0] = m_fault || (m_ocnt >= LIM);
            if (m_cnt == 2047) begin
                m_dl = map_d(lft_spd);
                m_dr = map_d(rght_spd);
                if (m_seen || hit) m_ocnt = (m_ocnt < 15) ? m_ocnt + 1 : 15;
                else m_ocnt = 0;
                m_seen = 1'b0;
            end else begin
                m_seen = m_seen || hit;
            end
            m_fault = e[0];
            m_cnt   = (m_cnt + 1) % 2048;
        end
        m_out = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs = {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, ovr_fault};
        check_val("cycle_outputs", int'(obs), int'(exp_q.pop_front()));
        n_l1 += int'(lft_PWM1);
        n_l2 += int'(lft_PWM2);
        n_r1 += int'(rght_PWM1);
        n_r2 += int'(rght_PWM2);
        n_sy += int'(PWM_synch);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic to_cnt(input int c);
        for (int i = 0; i < 2048 && m_cnt != c; i++) step();
    endtask

    initial begin
        rst = 1'b1; lft_spd = 12'd0; rght_spd = 12'd0; pwr_up = 1'b0; ovr_i = 1'b0;
        run_n(3);
        check_val("reset_pwm", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}), 0);
        check_val("reset_flags", int'({PWM_synch, ovr_fault}), 0);
        rst = 1'b0;
        pwr_up = 1'b1;
        rght_spd = 12'h7FF;

        // Neutral left, full positive right.
        run_n(2048);
        for (int p = 0; p < 2; p++) begin
            clear_win();
            run_n(2048);
            check_val("neutral_l1", n_l1, 992);
            check_val("neutral_l2", n_l2, 992);
            check_val("full_pos_r1", n_r1, 2015);
            check_val("full_pos_r2", n_r2, 0);
            check_val("synch_per_period", n_sy, 1);
        end

        // Full negative right.
        rght_spd = 12'h800;
        run_n(2048);
        clear_win();
        run_n(2048);
        check_val("full_neg_r1", n_r1, 0);
        check_val("full_neg_r2", n_r2, 2016);

        // Mid-period command change only takes effect next period.
        clear_win();
        run_n(500);
        lft_spd = 12'd1000;
        run_n(1548);
        check_val("mid_cur_l1", n_l1, 992);
        clear_win();
        run_n(2048);
        check_val("mid_next_l1", n_l1, 1492);
        check_val("mid_next_l2", n_l2, 492);
        check_val("mid_next_synch", n_sy, 1);

        // Over-current in four consecutive periods latches the fault.
        lft_spd = 12'd0;
        ovr_i = 1'b1;
        run_n(4 * 2048);
        run_n(2);
        check_val("ovr_latch", int'(ovr_fault), 1);
        check_val("ovr_pwm_off", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}), 0);
        ovr_i = 1'b0;
        pwr_up = 1'b0;
        run_n(100);
        pwr_up = 1'b1;
        run_n(100);
        check_val("ovr_hold", int'(ovr_fault), 1);
        rst = 1'b1;
        run_n(1);
        rst = 1'b0;
        check_val("ovr_rst_clear", int'(ovr_fault), 0);

        // Three hits, one clean period, three hits: counter clears, no fault.
        for (int p = 0; p < 7; p++) begin
            ovr_i = (p != 3);
            run_n(2048);
        end
        ovr_i = 1'b0;
        run_n(2048);
        check_val("ovr_clear", int'(ovr_fault), 0);

        // Over-current while coasting is ignored.
        pwr_up = 1'b0;
        run_n(2);
        ovr_i = 1'b1;
        run_n(5 * 2048);
        check_val("ovr_mask", int'(ovr_fault), 0);
        ovr_i = 1'b0;

        // Reset mid-period returns to neutral duty for the next period.
        pwr_up = 1'b1;
        lft_spd = 12'h7FF;
        run_n(2048);
        to_cnt(1200);
        rst = 1'b1;
        run_n(1);
        rst = 1'b0;
        check_val("rstmid_out", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch}), 0);
        clear_win();
        run_n(2048);
        check_val("rstmid_l1", n_l1, 992);
        check_val("rstmid_synch", n_sy, 1);
        clear_win();
        run_n(2048);
        check_val("rstmid_next_l1", n_l1, 2015);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mtr_drv.md
# mtr_drv

Motor drive block on the output side of the balance controller. It consumes the signed wheel speed commands (`lft_spd`, `rght_spd`) and produces complementary, dead-time-protected PWM pairs for the left and right H-bridges. Duty is updated only at PWM period boundaries. A period-counted over-current monitor latches a shutdown.

## Interface
- `NONOVERLAP`, default 32: dead time in clocks between one half of a pair falling and the other rising. Legal range 1..255.
- `OVR_LIMIT`, default 4: number of consecutive PWM periods with over-current that latches shutdown. Legal range 1..15.
- `clk` input, 1 bit: system clock. Every register is clocked on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `lft_spd` input, 12 bits: signed left wheel speed command.
- `rght_spd` input, 12 bits: signed right wheel speed command.
- `pwr_up` input, 1 bit: drive enable. When low, all PWM outputs are 0 (coast).
- `ovr_i` input, 1 bit: over-current comparator from the bridge. Treat as already synchronous.
- `lft_PWM1`, `lft_PWM2` output, 1 bit each: left bridge high-side and low-side drive.
- `rght_PWM1`, `rght_PWM2` output, 1 bit each: right bridge high-side and low-side drive.
- `PWM_synch` output, 1 bit: one-clock pulse at the start of each PWM period.
- `ovr_fault` output, 1 bit: latched over-current shutdown flag.

## Operation
- **Period counter.** `cnt` is an 11-bit free-running counter. It counts 0..2047 and wraps 2047→0, so one period is 2048 clocks.
- **Duty mapping.** `duty = {~spd[11], spd[10:1]}` (11 bits, unsigned).
  - spd 0 → 1024 (50%).
  - +2047 → 2047.
  - −2048 → 0.
  - No saturation logic is needed.
- **Double buffering.** The duty registers sample the mapped inputs only in the cycle where `cnt==2047`. The new value governs the period starting at `cnt==0`. Changes to the speed inputs at any other time have no effect on the current period.
- **Output rule.** All PWM outputs are registered. For each side:
  - `PWM1(t+1) = run && cnt(t) >= NONOVERLAP && cnt(t) < duty`
  - `PWM2(t+1) = run && cnt(t) >= duty+NONOVERLAP`
  - The comparison `duty+NONOVERLAP` is evaluated at 12 bits. A sum above 2047 means PWM2 stays low all period.
  - `run = pwr_up && !ovr_fault`.
- **No-overlap guarantee.** PWM1 and PWM2 of one side are never both 1. Either output rising requires both to have been 0 for at least NONOVERLAP clocks.
- **Duty edge cases.** If `duty <= NONOVERLAP`, PWM1 stays low all period.
- **PWM_synch.** Registered; equals 1 in the cycle following `cnt==2047`, i.e. once per 2048 clocks. It is independent of `run`.
- **Over-current monitor.**
  - `ovr_seen` is set when `ovr_i` is 1 while any of the four PWM outputs is 1.
  - At `cnt==2047`:
    - If `ovr_seen` (including a hit in that same cycle) is set, the 4-bit `ovr_cnt` increments.
    - Otherwise `ovr_cnt` clears.
    - `ovr_seen` clears in the same cycle.
  - When `ovr_cnt` reaches OVR_LIMIT, `ovr_fault` sets in the next cycle. It stays set until `rst`, and `pwr_up` cannot clear it.
  - `ovr_i` with all outputs low is ignored.
- **Reset values** (when `rst` is 1, applied at the next edge):
  - `cnt`=0; both duty registers=1024.
  - All PWM outputs=0; `PWM_synch`=0.
  - `ovr_seen`=0, `ovr_cnt`=0, `ovr_fault`=0.
- **Reset mid-period** aborts the period immediately. The first period after reset uses duty 1024 until the first `cnt==2047` sample.

## Timing
- **Command to output latency:**
  - Best case (input valid at `cnt==2047`): 1 clock to the duty register, then the output edge at its `cnt` threshold plus 1 clock.
  - Worst case: one full period (2048 clocks) plus edge offset.
- **Edge timing.** The PWM1 rising edge appears 1 clock after `cnt==NONOVERLAP`. The falling edge appears 1 clock after `cnt==duty`.
- **`pwr_up` response.** Falling `pwr_up` forces all outputs low on the next edge. Rising `pwr_up` resumes on the next edge at the current `cnt` position; the dead-time rule still holds because the ranges are disjoint.
- **Simultaneous events.** If `rst` and `cnt==2047` occur together, `rst` wins. An `ovr_i` hit in the sampling cycle counts toward the current period.
- **Fault timing.** `ovr_fault` asserts 1 clock after the period-end that makes `ovr_cnt==OVR_LIMIT`. The PWM outputs go to 0 one further clock later.

## Test plan
- **Neutral duty.** Reset, then `lft_spd`=0, `pwr_up`=1, run 3 periods → `lft_PWM1` high 992 clocks per period, `lft_PWM2` high 992 clocks, never both high, gaps ≥32 clocks.
- **Full scale.** `rght_spd`=12'h7FF → PWM1 high 2015 clocks, PWM2 never high. `rght_spd`=12'h800 → PWM1 never high, PWM2 high 2016 clocks.
- **Mid-period change.** Change `lft_spd` 0→+1000 at `cnt`=500 → the current period stays at duty 1024; the next period uses duty 1524 (PWM1 high 1492 clocks). `PWM_synch` pulses exactly every 2048 clocks.
- **Over-current latch.** Hold `ovr_i`=1 for 4 consecutive periods with `pwr_up`=1 → `ovr_fault`=1 after the 4th period end and all PWM outputs are 0 thereafter. Dropping `pwr_up` does not clear it; only `rst` does.
- **Counter clearing and masking.** Assert `ovr_i` in 3 periods, leave 1 clean period, then 3 more → no fault (counter cleared). Assert `ovr_i` with `pwr_up`=0 → no count.
- **Reset mid-period.** Assert `rst` at `cnt`=1200 with `lft_spd`=12'h7FF → the next cycle shows all outputs 0 and `cnt`=0; the following period uses duty 1024.
